// File: rtl/vram_pkg.sv
// Shared widths, entry payload and address packing for the VRAM write path.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 20;
    localparam int unsigned VRAM_DATA_W = 36;
    localparam int unsigned PIXEL_W     = 18;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned TAG_W       = 2 * COORD_W - 1;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } vram_entry_t;

    // Two pixels share one word, so the column LSB selects the half, not the address.
    function automatic logic [VRAM_ADDR_W-1:0] vram_addr(input logic [COORD_W-1:0] y,
                                                         input logic [COORD_W-1:0] x);
        return {1'b0, y, x[COORD_W-1:1]};
    endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Queue of packed {addr,data} words awaiting a VRAM grant; push into full is ignored
// unless a pop happens in the same cycle.
module vram_write_fifo
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        push,
    input  logic        pop,
    input  vram_entry_t din,
    output vram_entry_t dout_c,
    output logic        full,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    vram_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty_q;
        do_push  = push && (!full_q || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout_c = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/vram_writer.sv
// Packs pixel pairs into 36-bit words and streams them to a ZBT VRAM port.
// Optional VRAM_WRITER_DROP_COUNT_EN adds an 8-bit saturating dropped-word counter.
module vram_writer
    import vram_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WRITE_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   pixelValid,
    input  logic [PIXEL_W-1:0]     pixel,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic                   frameStart,
    input  logic                   vramGrant,
    output logic                   vramWe,
    output logic [VRAM_ADDR_W-1:0] vramAddr,
    output logic [VRAM_DATA_W-1:0] vramData,
`ifdef VRAM_WRITER_DROP_COUNT_EN
    output logic [7:0]             dropCount,
`endif
    output logic                   overflow
);

    logic [PIXEL_W-1:0]     held_q, held_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   tag_vld_q, tag_vld_d;
    logic                   we_q, we_d;
    logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [VRAM_DATA_W-1:0] pipe_q [WRITE_LAT+1];
    logic [VRAM_DATA_W-1:0] pipe_d [WRITE_LAT+1];
    logic                   overflow_q, overflow_d;
    logic [TAG_W-1:0]       pix_tag;
    logic [PIXEL_W-1:0]     upper;
    logic                   push_c, pop_c, drop_c;
    logic                   fifo_full, fifo_empty;
    vram_entry_t            push_entry, pop_entry;

    assign pix_tag = {y, x[COORD_W-1:1]};

    // Packer, issue and data-delay next state.
    always_comb begin
        held_d    = held_q;
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        if (frameStart) tag_vld_d = 1'b0;
        if (pixelValid && !x[0]) begin
            held_d    = pixel;
            tag_d     = pix_tag;
            tag_vld_d = 1'b1;
        end

        upper           = (tag_vld_q && (tag_q == pix_tag)) ? held_q : '0;
        push_c          = pixelValid && x[0];
        push_entry.addr = vram_addr(y, x);
        push_entry.data = {upper, pixel};

        pop_c  = !fifo_empty && vramGrant;
        drop_c = push_c && fifo_full && !pop_c;

        we_d      = pop_c;
        addr_d    = pop_c ? pop_entry.addr : '0;
        pipe_d[0] = pop_c ? pop_entry.data : '0;
        for (int i = 1; i <= int'(WRITE_LAT); i++) pipe_d[i] = pipe_q[i-1];

        overflow_d = drop_c ? 1'b1 : (frameStart ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            held_q     <= '0;
            tag_q      <= '0;
            tag_vld_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i <= int'(WRITE_LAT); i++) pipe_q[i] <= '0;
        end else begin
            held_q     <= held_d;
            tag_q      <= tag_d;
            tag_vld_q  <= tag_vld_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
            for (int i = 0; i <= int'(WRITE_LAT); i++) pipe_q[i] <= pipe_d[i];
        end
    end

    vram_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (push_c),
        .pop    (pop_c),
        .din    (push_entry),
        .dout_c (pop_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign vramWe   = we_q;
    assign vramAddr = addr_q;
    assign vramData = pipe_q[WRITE_LAT];
    assign overflow = overflow_q;

`ifdef VRAM_WRITER_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] drop_base;

    // A drop in the frameStart cycle counts toward the new frame.
    always_comb begin
        drop_base  = frameStart ? 8'h00 : drop_cnt_q;
        drop_cnt_d = (drop_c && (drop_base != 8'hFF)) ? drop_base + 8'd1 : drop_base;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) drop_cnt_q <= '0;
        else         drop_cnt_q <= drop_cnt_d;
    end

    assign dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_vram_writer.sv
// Scoreboard bench for vram_writer: stimulus queues expected words, a monitor checks writes.
module tb_vram_writer;
    import vram_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetN, pixelValid, frameStart, vramGrant;
    logic [17:0] pixel;
    logic [9:0]  x, y;
    logic        vramWe, overflow;
    logic [19:0] vramAddr;
    logic [35:0] vramData;
`ifdef VRAM_WRITER_DROP_COUNT_EN
    logic [7:0]  dropCount;
`endif

    typedef struct packed {
        logic [19:0] a;
        logic [35:0] d;
    } exp_t;

    typedef struct {
        int          due;
        logic [35:0] d;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    exp_t  mon_e;
    pend_t mon_p;
    int    checks = 0, errors = 0, cyc = 0, we_seen = 0, we_before = 0;

    vram_writer #(.FIFO_DEPTH(4), .WRITE_LAT(LAT)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .pixelValid (pixelValid),
        .pixel      (pixel),
        .x          (x),
        .y          (y),
        .frameStart (frameStart),
        .vramGrant  (vramGrant),
        .vramWe     (vramWe),
        .vramAddr   (vramAddr),
        .vramData   (vramData),
`ifdef VRAM_WRITER_DROP_COUNT_EN
        .dropCount  (dropCount),
`endif
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [19:0] a, input logic [35:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [9:0] px, input logic [9:0] py, input logic [17:0] p);
        pixelValid = 1'b1;
        x          = px;
        y          = py;
        pixel      = p;
        @(posedge clk);
        #1;
        pixelValid = 1'b0;
        frameStart = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare each write address, then its data LAT cycles later.
    always @(negedge clk) begin
        cyc++;
        if (!resetN) begin
            exp_q.delete();
            pend_q.delete();
        end else begin
            if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                mon_p = pend_q.pop_front();
                check("vramData", 64'(vramData), 64'(mon_p.d));
            end else if (vramData !== '0) begin
                check("idle_vramData", 64'(vramData), 64'(0));
            end
            if (vramWe) begin
                we_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_vramWe", 64'(vramWe), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check("vramAddr", 64'(vramAddr), 64'(mon_e.a));
                    pend_q.push_back('{due: cyc + LAT, d: mon_e.d});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; pixelValid = 1'b0; frameStart = 1'b0; vramGrant = 1'b0;
        pixel = '0; x = '0; y = '0;
        #12;
        check("rst_vramWe", 64'(vramWe), 64'(0));
        check("rst_vramAddr", 64'(vramAddr), 64'(0));
        check("rst_vramData", 64'(vramData), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        @(posedge clk); #1;
        resetN = 1'b1;
        idle(1);

        // Basic pair with latency check
        vramGrant = 1'b1;
        expect_word(20'h00A00, 36'hFFFFC0001);
        send(10'd0, 10'd5, 18'h3FFFF);
        send(10'd1, 10'd5, 18'h00001);
        check("latency_cycle1", 64'(vramWe), 64'(0));
        idle(1);
        check("latency_cycle2", 64'(vramWe), 64'(1));
        idle(6);

        // Odd pixel without partner
        expect_word(20'h00403, 36'h00002AAAA);
        send(10'd7, 10'd2, 18'h2AAAA);
        idle(6);

        // Second even overwrites held half
        expect_word(20'h00201, 36'h8888B3333);
        send(10'd2, 10'd1, 18'h11111);
        send(10'd2, 10'd1, 18'h22222);
        send(10'd3, 10'd1, 18'h33333);
        idle(6);

        // Held tag mismatch gives zero upper half
        expect_word(20'h00603, 36'h000000077);
        send(10'd4, 10'd3, 18'h12345);
        send(10'd7, 10'd3, 18'h00077);
        idle(6);

        // Overflow with grant low, then frameStart while queue non-empty
        vramGrant = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_word(20'h01000 + 20'(i), {18'h00100 + 18'(i), 18'h00200 + 18'(i)});
            send(10'(2 * i), 10'd8, 18'h00100 + 18'(i));
            send(10'(2 * i + 1), 10'd8, 18'h00200 + 18'(i));
        end
        check("ovf_set", 64'(overflow), 64'(1));
`ifdef VRAM_WRITER_DROP_COUNT_EN
        check("drop_count_2", 64'(dropCount), 64'(2));
`endif
        frameStart = 1'b1;
        @(posedge clk); #1;
        frameStart = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'(0));
`ifdef VRAM_WRITER_DROP_COUNT_EN
        check("drop_count_clr", 64'(dropCount), 64'(0));
`endif
        vramGrant = 1'b1;
        idle(12);
        check("drain_after_frame", 64'(exp_q.size()), 64'(0));

        // Push into full FIFO with same-cycle pop
        vramGrant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_word(20'h01200 + 20'(i), {18'h00300 + 18'(i), 18'h00310 + 18'(i)});
            send(10'(2 * i), 10'd9, 18'h00300 + 18'(i));
            if (i == 4) vramGrant = 1'b1;
            send(10'(2 * i + 1), 10'd9, 18'h00310 + 18'(i));
        end
        check("full_pushpop_ovf", 64'(overflow), 64'(0));
        idle(12);
        check("drain_full", 64'(exp_q.size()), 64'(0));

        // Drop coincident with frameStart keeps overflow set
        vramGrant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_word(20'h01400 + 20'(i), {18'h00400 + 18'(i), 18'h00410 + 18'(i)});
            send(10'(2 * i), 10'd10, 18'h00400 + 18'(i));
            send(10'(2 * i + 1), 10'd10, 18'h00410 + 18'(i));
        end
        send(10'd8, 10'd10, 18'h00404);
        frameStart = 1'b1;
        send(10'd9, 10'd10, 18'h00414);
        check("ovf_set_wins", 64'(overflow), 64'(1));
`ifdef VRAM_WRITER_DROP_COUNT_EN
        check("drop_count_frame", 64'(dropCount), 64'(1));
`endif

        // Reset mid-burst: one word in flight, three queued
        vramGrant = 1'b1;
        @(posedge clk); #1;
        vramGrant = 1'b0;
        check("burst_we", 64'(vramWe), 64'(1));
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        check("midrst_vramWe", 64'(vramWe), 64'(0));
        check("midrst_vramAddr", 64'(vramAddr), 64'(0));
        check("midrst_vramData", 64'(vramData), 64'(0));
        check("midrst_overflow", 64'(overflow), 64'(0));
        idle(2);
        we_before = we_seen;
        resetN    = 1'b1;
        vramGrant = 1'b1;
        idle(8);
        check("post_reset_no_we", 64'(we_seen - we_before), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
